adiv5_arbiter: RTL
==================

Name: adiv5_arbiter

Overview:
- Shares one ADIv5 debug-port command/response FIFO pair (jtag_adiv5 or its SWD sibling) between NREQ requesters, e.g. the AHB3-lite remote bridge and the host debug channel.
- Grants command access round-robin. A requester may hold a lock so that a SELECT write followed by AP accesses is never interleaved with another requester's commands.
- Records the owner of every outstanding read in an in-order tag FIFO and routes each returned response back to that owner.

Parameters:
- NREQ, 2, number of requesters (2..8).
- TAG_AW, 2, log2 of maximum outstanding reads (tag FIFO depth 2**TAG_AW).

Ports:
- CLK  in  1  clock
- RESET  in  1  synchronous active-high reset
- REQ_VALID  in  NREQ  per-requester command valid
- REQ_LOCK  in  NREQ  per-requester grant lock
- REQ_CMD  in  40*NREQ  commands; requester i at [40*i+39:40*i]; format DATA[31:0], ADDR[5:0], APnDP, RnW
- REQ_READY  out  NREQ  command accepted this cycle
- RSP_DATA  out  35  response DATA[31:0], STAT[2:0]; shared by all requesters
- RSP_VALID  out  NREQ  response valid; one-hot, asserted only for the owner
- RSP_READY  in  NREQ  response consumed
- WRDATA  out  40  downstream command
- WREN  out  1  downstream command write
- WRFULL  in  1  downstream command FIFO full
- RDDATA  in  35  downstream response
- RDEN  out  1  downstream response read
- RDEMPTY  in  1  downstream response FIFO empty
- OUTSTANDING  out  TAG_AW+1  reads issued but not yet returned
- ERR  out  1  one-cycle pulse on an orphan response

Behaviour:
- Reset values:
  - All outputs 0; RSP_DATA 0; arbiter state ARB; round-robin pointer 0.
  - Tag FIFO emptied. Tags in flight are discarded, and responses arriving later are treated as orphans.
- Downstream contract: every command with RnW=1 returns exactly one response, in issue order. Commands with RnW=0 return none.
- Command FSM, ARB state:
  - If any REQ_VALID is high, grant the first valid requester found searching from pointer, pointer+1, ... (mod NREQ), then go to OWN.
  - Arbitration costs one cycle. No REQ_READY is asserted in ARB.
- Command FSM, OWN state (granted requester g):
  - Accept when REQ_VALID[g] and !WRFULL, and additionally tag FIFO not full if the command's RnW=1.
  - On accept, combinationally in the same cycle: REQ_READY[g]=1, WREN=1, WRDATA=REQ_CMD[g]. If RnW=1, push g into the tag FIFO.
  - After an accept with REQ_LOCK[g]=0: set pointer to g+1 and go to ARB.
  - With no accept: if REQ_VALID[g]=0 and REQ_LOCK[g]=0, go to ARB. Otherwise stay in OWN; a locked owner holds the grant while idle.
  - With REQ_LOCK[g]=1: stay in OWN after each accept. Released when LOCK drops.
- WREN is never asserted while WRFULL=1. At most one REQ_READY is high per cycle.
- Response path, three states:
  - R_IDLE: if !RDEMPTY, assert RDEN for one cycle and go to R_CAP.
  - R_CAP: downstream data is valid one cycle after RDEN. Register RDDATA into RSP_DATA and pop the tag.
    - Tag FIFO non-empty: the popped id becomes the owner; RSP_VALID[owner]=1; go to R_HOLD.
    - Tag FIFO empty: pulse ERR, drop the data, return to R_IDLE.
  - R_HOLD: hold RSP_DATA and RSP_VALID until RSP_READY[owner]=1, then clear both and return to R_IDLE.
- Response throughput is one response per 3 cycles maximum. RDEN is never asserted outside R_IDLE.
- The command and response paths run independently. A tag push and pop in the same cycle leaves OUTSTANDING unchanged.
- OUTSTANDING = tag FIFO occupancy, range 0..2**TAG_AW.
- RSP_READY of non-owners is ignored. Stray REQ_VALID from non-granted requesters is held off (REQ_READY=0).
- If the owner deasserts REQ_VALID mid-OWN with LOCK low, no command is issued and the FSM re-arbitrates.

Test Plan:
- Fairness: requesters 0 and 1 both stream writes, LOCK=0 -> WRDATA alternates 0,1,0,1. WREN pulses every 2 cycles; no command is lost or duplicated.
- Lock: req0 asserts LOCK, issues a SELECT write (addr 0x8, DP), idles 5 cycles, then issues an AP read. req1 is valid throughout -> req1 gets no REQ_READY until req0 drops LOCK, then req1 is granted within 2 cycles.
- Routing: req0 read, req1 read, req0 read issued back-to-back. Downstream returns STAT=100 with data 0x11, 0x22, 0x33 -> RSP_VALID one-hot sequence 0,1,0 with matching RSP_DATA. OUTSTANDING steps 3,2,1,0.
- Backpressure:
  - WRFULL=1 for 10 cycles -> WREN=0 and REQ_READY=0 throughout; the command issues the cycle WRFULL falls.
  - TAG_AW=2 with 4 reads outstanding -> a 5th read stalls while writes still pass.
  - RSP_READY held low 8 cycles -> RDEN stays 0 and the next response waits.
- Orphan/reset: 2 reads outstanding, then RESET for 1 cycle -> all outputs 0 and OUTSTANDING=0. Each of the 2 responses that later arrive pulses ERR and raises no RSP_VALID.

Source files
------------

// File: rtl/adiv5_arbiter_if.sv
// adiv5_arbiter_if: requester, downstream FIFO and status signals of the ADIv5 DP arbiter
interface adiv5_arbiter_if #(
  parameter int NREQ = 2,
  parameter int TAG_AW = 2
);
  logic [NREQ-1:0] REQ_VALID, REQ_LOCK, REQ_READY, RSP_VALID, RSP_READY;
  logic [40*NREQ-1:0] REQ_CMD;
  logic [34:0] RSP_DATA, RDDATA;
  logic [39:0] WRDATA;
  logic WREN, WRFULL, RDEN, RDEMPTY, ERR;
  logic [TAG_AW:0] OUTSTANDING;
  modport slave(
    input REQ_VALID, REQ_LOCK, REQ_CMD, RSP_READY, WRFULL, RDDATA, RDEMPTY,
    output REQ_READY, RSP_DATA, RSP_VALID, WRDATA, WREN, RDEN, OUTSTANDING, ERR
  );
  modport master(
    output REQ_VALID, REQ_LOCK, REQ_CMD, RSP_READY, WRFULL, RDDATA, RDEMPTY,
    input REQ_READY, RSP_DATA, RSP_VALID, WRDATA, WREN, RDEN, OUTSTANDING, ERR
  );
endinterface

// File: rtl/adiv5_arbiter.sv
// adiv5_arbiter: round-robin/lockable sharing of one ADIv5 DP command/response FIFO pair
module adiv5_arbiter #(
  parameter int NREQ = 2,
  parameter int TAG_AW = 2
) (
  input logic CLK,
  input logic RESET,
  adiv5_arbiter_if.slave bus
);
  localparam int IW = NREQ > 1 ? $clog2(NREQ) : 1;
  localparam int DEPTH = 1 << TAG_AW;
  typedef enum logic {ARB, OWN} cstate_t;
  typedef enum logic [1:0] {R_IDLE, R_CAP, R_HOLD} rstate_t;
  cstate_t cs_q, cs_d;
  rstate_t rs_q, rs_d;
  logic [IW-1:0] ptr_q, ptr_d, gnt_q, gnt_d, owner_q, owner_d, sel;
  logic [IW-1:0] tag_q [DEPTH];
  logic [IW-1:0] tag_d [DEPTH];
  logic [TAG_AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [TAG_AW:0] cnt_q, cnt_d;
  logic [34:0] rsp_data_q, rsp_data_d;
  logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
  logic err_q, err_d, found, accept, push, pop;
  logic [39:0] cmd;
  always_comb begin
    found = 1'b0;
    sel = ptr_q;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && bus.REQ_VALID[(int'(ptr_q) + i) % NREQ]) begin
        found = 1'b1;
        sel = IW'((int'(ptr_q) + i) % NREQ);
      end
    end
  end
  // reads additionally need a free tag slot; writes never wait on the tag FIFO
  assign cmd = bus.REQ_CMD[40*gnt_q +: 40];
  assign accept = cs_q == OWN && bus.REQ_VALID[gnt_q] && !bus.WRFULL &&
                  (!cmd[0] || cnt_q != (TAG_AW+1)'(DEPTH));
  assign push = accept && cmd[0];
  assign pop = rs_q == R_CAP && cnt_q != '0;
  assign bus.WREN = accept;
  assign bus.WRDATA = accept ? cmd : '0;
  assign bus.REQ_READY = accept ? NREQ'(1) << gnt_q : '0;
  assign bus.RDEN = rs_q == R_IDLE && !bus.RDEMPTY;
  assign bus.RSP_DATA = rsp_data_q;
  assign bus.RSP_VALID = rsp_valid_q;
  assign bus.OUTSTANDING = cnt_q;
  assign bus.ERR = err_q;
  always_comb begin
    cs_d = cs_q;
    gnt_d = gnt_q;
    ptr_d = ptr_q;
    if (cs_q == ARB) begin
      cs_d = found ? OWN : ARB;
      gnt_d = found ? sel : gnt_q;
    end else if (!bus.REQ_LOCK[gnt_q] && (accept || !bus.REQ_VALID[gnt_q])) begin
      cs_d = ARB;
      ptr_d = !accept ? ptr_q : (int'(gnt_q) == NREQ - 1) ? '0 : gnt_q + 1'b1;
    end
  end
  always_comb begin
    tag_d = tag_q;
    wp_d = wp_q + TAG_AW'(push);
    rp_d = rp_q + TAG_AW'(pop);
    cnt_d = cnt_q + (TAG_AW+1)'(push) - (TAG_AW+1)'(pop);
    if (push) tag_d[wp_q] = gnt_q;
  end
  // an empty tag FIFO at capture time means the response has no owner
  always_comb begin
    rs_d = rs_q;
    rsp_data_d = rsp_data_q;
    rsp_valid_d = rsp_valid_q;
    owner_d = owner_q;
    err_d = 1'b0;
    if (rs_q == R_IDLE) begin
      rs_d = bus.RDEMPTY ? R_IDLE : R_CAP;
    end else if (rs_q == R_CAP) begin
      rs_d = pop ? R_HOLD : R_IDLE;
      err_d = !pop;
      owner_d = pop ? tag_q[rp_q] : owner_q;
      rsp_data_d = pop ? bus.RDDATA : rsp_data_q;
      rsp_valid_d = pop ? NREQ'(1) << tag_q[rp_q] : rsp_valid_q;
    end else if (bus.RSP_READY[owner_q]) begin
      rs_d = R_IDLE;
      rsp_data_d = '0;
      rsp_valid_d = '0;
    end
  end
  always_ff @(posedge CLK) begin
    if (RESET) begin
      cs_q <= ARB;
      rs_q <= R_IDLE;
      ptr_q <= '0;
      gnt_q <= '0;
      owner_q <= '0;
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
      rsp_data_q <= '0;
      rsp_valid_q <= '0;
      err_q <= 1'b0;
    end else begin
      cs_q <= cs_d;
      rs_q <= rs_d;
      ptr_q <= ptr_d;
      gnt_q <= gnt_d;
      owner_q <= owner_d;
      wp_q <= wp_d;
      rp_q <= rp_d;
      cnt_q <= cnt_d;
      rsp_data_q <= rsp_data_d;
      rsp_valid_q <= rsp_valid_d;
      err_q <= err_d;
    end
  end
  always_ff @(posedge CLK) tag_q <= tag_d;
endmodule
